fsm_ctrl_param: RTL and testbench

Parametrised successor of the FIFO-subsystem control FSM. Sequences the N-FIFO datapath through RESET, INIT, IDLE, ACTIVE and ERROR.
- Latches and validates the high/low watermark thresholds fed to the FIFOs.
- Filters the idle decision with a consecutive-empty counter.
- Records which FIFOs raised an error.
- Sits between the configuration/test harness and the FIFO array, driving their threshold and status inputs.

---
 rtl/fsm_ctrl_param.sv | 121 ++++++++++++
 tb/tb_fsm_ctrl_param.sv | 123 ++++++++++++
 2 files changed

// File: rtl/fsm_ctrl_param.sv
// Control FSM for an N-FIFO datapath: latches/validates watermark thresholds,
// filters the idle decision over consecutive all-empty cycles, records FIFO errors.
module fsm_ctrl_param #(
    parameter int NFIFO    = 10,
    parameter int TW       = 3,
    parameter int IDLE_CYC = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic [TW-1:0]    umbral_alto,
    input  logic [TW-1:0]    umbral_bajo,
    input  logic [NFIFO-1:0] FIFO_empty,
    input  logic [NFIFO-1:0] FIFO_error,
    output logic [TW-1:0]    interno_alto,
    output logic [TW-1:0]    interno_bajo,
    output logic             idle,
    output logic             error,
    output logic             cfg_err,
    output logic [NFIFO-1:0] err_fifo,
    output logic [2:0]       state
);

    localparam int CW = $clog2(IDLE_CYC + 1);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_INIT   = 3'd1,
        S_IDLE   = 3'd2,
        S_ACTIVE = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_nxt;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_nxt;
    logic [TW-1:0]     r_alto;
    logic [TW-1:0]     r_bajo;
    logic              r_cfg_valid;
    logic              r_cfg_err;
    logic              r_idle;
    logic              r_error;
    logic [NFIFO-1:0]  r_err_fifo;
    logic              w_all_empty;
    logic              w_any_err;
    logic              w_cfg_ok;

    assign w_all_empty = &FIFO_empty;
    assign w_any_err   = |FIFO_error;
    assign w_cfg_ok    = umbral_bajo < umbral_alto;

    always_comb begin
        w_nxt     = r_state;
        w_cnt_nxt = '0;
        case (r_state)
            S_RESET: w_nxt = S_INIT;
            S_INIT: begin
                if (!init && r_cfg_valid) w_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (w_any_err)         w_nxt = S_ERROR;
                else if (init)         w_nxt = S_INIT;
                else if (!w_all_empty) w_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (w_any_err)      w_nxt = S_ERROR;
                else if (init)      w_nxt = S_INIT;
                else if (w_all_empty) begin
                    // The current cycle is the IDLE_CYC-th consecutive all-empty one
                    if (r_cnt >= CW'(IDLE_CYC - 1)) w_nxt = S_IDLE;
                    else if (r_cnt < CW'(IDLE_CYC)) w_cnt_nxt = r_cnt + CW'(1);
                    else                            w_cnt_nxt = r_cnt;
                end
            end
            S_ERROR: w_nxt = S_ERROR;
            default: w_nxt = S_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_RESET;
            r_cnt       <= '0;
            r_alto      <= '0;
            r_bajo      <= '0;
            r_cfg_valid <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_idle      <= 1'b0;
            r_error     <= 1'b0;
            r_err_fifo  <= '0;
        end else begin
            r_state <= w_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idle  <= (w_nxt == S_IDLE);
            r_error <= (w_nxt == S_ERROR);
            if (r_state == S_INIT && init) begin
                if (w_cfg_ok) begin
                    r_alto      <= umbral_alto;
                    r_bajo      <= umbral_bajo;
                    r_cfg_valid <= 1'b1;
                    r_cfg_err   <= 1'b0;
                end else begin
                    r_cfg_err   <= 1'b1;
                end
            end else if (r_state != S_INIT && w_nxt == S_INIT) begin
                r_cfg_valid <= 1'b0;
            end
            if (w_nxt == S_ERROR) r_err_fifo <= r_err_fifo | FIFO_error;
        end
    end

    assign interno_alto = r_alto;
    assign interno_bajo = r_bajo;
    assign idle         = r_idle;
    assign error        = r_error;
    assign cfg_err      = r_cfg_err;
    assign err_fifo     = r_err_fifo;
    assign state        = r_state;

endmodule

// File: tb/tb_fsm_ctrl_param.sv
// Directed, table-driven bench for fsm_ctrl_param (NFIFO=10, TW=3, IDLE_CYC=2).
module tb_fsm_ctrl_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       init;
    logic [2:0] umbral_alto, umbral_bajo;
    logic [9:0] FIFO_empty, FIFO_error;
    logic [2:0] interno_alto, interno_bajo;
    logic       idle, error, cfg_err;
    logic [9:0] err_fifo;
    logic [2:0] state;

    int checks   = 0;
    int failures = 0;

    fsm_ctrl_param #(.NFIFO(10), .TW(3), .IDLE_CYC(2)) dut (
        .clk(clk), .reset(reset), .init(init),
        .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
        .FIFO_empty(FIFO_empty), .FIFO_error(FIFO_error),
        .interno_alto(interno_alto), .interno_bajo(interno_bajo),
        .idle(idle), .error(error), .cfg_err(cfg_err),
        .err_fifo(err_fifo), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       i_init;
        logic [2:0] i_alto, i_bajo;
        logic [9:0] i_empty, i_err;
        logic [2:0] e_state, e_alto, e_bajo;
        logic       e_idle, e_error, e_cfg;
        logic [9:0] e_ef;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic ii, logic [2:0] ia, logic [2:0] ib, logic [9:0] ie,
                                logic [9:0] ir, logic [2:0] es, logic [2:0] ea,
                                logic [2:0] eb, logic eid, logic eer, logic ec,
                                logic [9:0] ef);
        vec_t v;
        v.i_init = ii; v.i_alto = ia; v.i_bajo = ib; v.i_empty = ie; v.i_err = ir;
        v.e_state = es; v.e_alto = ea; v.e_bajo = eb;
        v.e_idle = eid; v.e_error = eer; v.e_cfg = ec; v.e_ef = ef;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check({tag, ".state"},    32'(state),        32'(v.e_state));
        check({tag, ".alto"},     32'(interno_alto), 32'(v.e_alto));
        check({tag, ".bajo"},     32'(interno_bajo), 32'(v.e_bajo));
        check({tag, ".idle"},     32'(idle),         32'(v.e_idle));
        check({tag, ".error"},    32'(error),        32'(v.e_error));
        check({tag, ".cfg_err"},  32'(cfg_err),      32'(v.e_cfg));
        check({tag, ".err_fifo"}, 32'(err_fifo),     32'(v.e_ef));
    endtask

    initial begin
        vec_t z;
        //                 init alto bajo empty   err     st  ea  eb idl er cfg ef
        vq.push_back(mk(0, 0, 0, 10'h3FF, 10'h000, 1, 0, 0, 0, 0, 0, 10'h000)); // RESET->INIT
        vq.push_back(mk(1, 3, 5, 10'h3FF, 10'h000, 1, 0, 0, 0, 0, 1, 10'h000)); // invalid
        vq.push_back(mk(0, 3, 5, 10'h3FF, 10'h000, 1, 0, 0, 0, 0, 1, 10'h000)); // stuck in INIT
        vq.push_back(mk(1, 5, 1, 10'h3FF, 10'h000, 1, 5, 1, 0, 0, 0, 10'h000)); // valid
        vq.push_back(mk(1, 4, 4, 10'h3FF, 10'h000, 1, 5, 1, 0, 0, 1, 10'h000)); // equal=invalid, hold
        vq.push_back(mk(0, 4, 4, 10'h3FF, 10'h000, 2, 5, 1, 1, 0, 1, 10'h000)); // IDLE (earlier valid)
        vq.push_back(mk(1, 6, 2, 10'h3FF, 10'h000, 1, 5, 1, 0, 0, 1, 10'h000)); // IDLE->INIT, no load yet
        vq.push_back(mk(1, 6, 2, 10'h3FF, 10'h000, 1, 6, 2, 0, 0, 0, 10'h000)); // load 6/2
        vq.push_back(mk(0, 6, 2, 10'h3FF, 10'h000, 2, 6, 2, 1, 0, 0, 10'h000)); // IDLE
        vq.push_back(mk(0, 6, 2, 10'h3FE, 10'h000, 3, 6, 2, 0, 0, 0, 10'h000)); // ACTIVE
        vq.push_back(mk(0, 6, 2, 10'h3FF, 10'h000, 3, 6, 2, 0, 0, 0, 10'h000)); // empty 1
        vq.push_back(mk(0, 6, 2, 10'h3FE, 10'h000, 3, 6, 2, 0, 0, 0, 10'h000)); // breaks run
        vq.push_back(mk(0, 6, 2, 10'h3FF, 10'h000, 3, 6, 2, 0, 0, 0, 10'h000)); // empty 1
        vq.push_back(mk(0, 6, 2, 10'h3FF, 10'h000, 2, 6, 2, 1, 0, 0, 10'h000)); // empty 2 -> IDLE
        vq.push_back(mk(0, 6, 2, 10'h3FF, 10'h000, 2, 6, 2, 1, 0, 0, 10'h000)); // stay IDLE
        vq.push_back(mk(0, 6, 2, 10'h3FE, 10'h000, 3, 6, 2, 0, 0, 0, 10'h000)); // ACTIVE
        vq.push_back(mk(1, 7, 0, 10'h3FE, 10'h000, 1, 6, 2, 0, 0, 0, 10'h000)); // re-init
        vq.push_back(mk(1, 7, 0, 10'h3FE, 10'h000, 1, 7, 0, 0, 0, 0, 10'h000)); // load 7/0
        vq.push_back(mk(0, 7, 0, 10'h3FE, 10'h000, 2, 7, 0, 1, 0, 0, 10'h000)); // IDLE
        vq.push_back(mk(0, 7, 0, 10'h3FE, 10'h000, 3, 7, 0, 0, 0, 0, 10'h000)); // ACTIVE
        vq.push_back(mk(1, 7, 0, 10'h3FE, 10'h004, 4, 7, 0, 0, 1, 0, 10'h004)); // error beats init
        vq.push_back(mk(1, 7, 0, 10'h3FE, 10'h000, 4, 7, 0, 0, 1, 0, 10'h004)); // init ignored
        vq.push_back(mk(0, 7, 0, 10'h3FE, 10'h200, 4, 7, 0, 0, 1, 0, 10'h204)); // accumulate
        vq.push_back(mk(0, 7, 0, 10'h3FE, 10'h000, 4, 7, 0, 0, 1, 0, 10'h204)); // sticky

        reset = 1'b0; init = 1'b0; umbral_alto = '0; umbral_bajo = '0;
        FIFO_empty = 10'h3FF; FIFO_error = '0;
        z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h000);
        #2 check_all("rst", z);
        @(negedge clk) reset = 1'b1;

        foreach (vq[k]) begin
            init = vq[k].i_init; umbral_alto = vq[k].i_alto; umbral_bajo = vq[k].i_bajo;
            FIFO_empty = vq[k].i_empty; FIFO_error = vq[k].i_err;
            @(posedge clk); #1;
            check_all($sformatf("v%0d", k), vq[k]);
        end

        // Asynchronous reset mid-cycle while in ERROR
        #3 reset = 1'b0;
        #1 check_all("async", z);
        init = 1'b0; FIFO_error = '0; FIFO_empty = 10'h3FF;
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check_all("post_rst", mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 10'h000));
        @(posedge clk); #1;
        check("post_rst.stay_init", 32'(state), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
